// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone master interface: FSM encoding and
// default bus geometry.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } wb_state_e;

    localparam int WB_DW  = 32;
    localparam int WB_AW  = 32;
    localparam int WB_TMO = 255;

endpackage : wb_pkg

// File: rtl/wb_tmo_cnt.sv
// Bus timeout counter: counts stalled BUSY cycles and flags when TMO is reached.
// TMO = 0 disables the timeout entirely.
module wb_tmo_cnt #(
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    logic [CW-1:0] cnt_q;

    assign expired_o = (TMO != 0) && (cnt_q == CW'(TMO));

    // Count up while enabled; stop at TMO so the counter never wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                     cnt_q <= '0;
        else if (clr_i)                cnt_q <= '0;
        else if (en_i && !expired_o)   cnt_q <= cnt_q + CW'(1);
    end

endmodule : wb_tmo_cnt

// File: rtl/wb_master_if.sv
// Wishbone classic master bridging one pipeline stage to the bus. One request
// at a time; the response is held while the pipeline is stalled downstream.
module wb_master_if
    import wb_pkg::*;
#(
    parameter int DW     = WB_DW,
    parameter int AW     = WB_AW,
    parameter int STALLW = 6,
    parameter int STAGE  = 1,
    parameter int TMO    = WB_TMO
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [STALLW-1:0] stall_i,
    input  logic              flush_i,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [DW/8-1:0]   cpu_sel_i,
    input  logic [AW-1:0]     cpu_addr_i,
    input  logic [DW-1:0]     cpu_data_i,
    output logic [DW-1:0]     cpu_data_o,
    output logic              stallreq,
    output logic              bus_err_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic [DW-1:0]     wb_data_i,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_data_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o
);

    wb_state_e         state_q;
    logic [DW-1:0]     hold_q;
    logic [AW-1:0]     wb_addr_q;
    logic [DW-1:0]     wb_data_q;
    logic [DW/8-1:0]   wb_sel_q;
    logic              wb_we_q;
    logic              wb_stb_q;

    logic busy, start, tmo_exp, term_err, term_ack, done, stage_stall;
    logic stall_unused;

    // Only this stage's bit of the stall vector matters here.
    assign stall_unused = ^stall_i;
    assign stage_stall  = stall_i[STAGE];

    assign busy  = (state_q == BUSY);
    assign start = (state_q == IDLE) && cpu_ce_i && !flush_i;

    // Termination priority: flush beats error beats timeout beats ack.
    assign term_err = busy && !flush_i && (wb_err_i || tmo_exp);
    assign term_ack = busy && !flush_i && !wb_err_i && !tmo_exp && wb_ack_i;
    assign done     = term_err || term_ack;

    wb_tmo_cnt #(.TMO(TMO)) u_tmo (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (!busy),
        .en_i      (busy && !wb_ack_i && !wb_err_i),
        .expired_o (tmo_exp)
    );

    // Stall the pipeline from the request cycle until the terminating cycle;
    // gated by rstn so an in-flight transaction never stalls through reset.
    always_comb begin
        stallreq = rstn && (start || (busy && !flush_i && !done));
    end

    // Read data: live bus data on ack, held data in HOLD, zero otherwise.
    always_comb begin
        cpu_data_o = '0;
        if (rstn) begin
            if (term_ack)               cpu_data_o = wb_data_i;
            else if (state_q == HOLD)   cpu_data_o = hold_q;
        end
    end

    // Error pulse coincides with the terminating error/timeout cycle.
    always_comb begin
        bus_err_o = rstn && term_err;
    end

    // Bus FSM with registered Wishbone outputs and the response hold buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_sel_q  <= '0;
            wb_we_q   <= 1'b0;
            wb_stb_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        wb_addr_q <= cpu_addr_i;
                        wb_data_q <= cpu_data_i;
                        wb_sel_q  <= cpu_sel_i;
                        wb_we_q   <= cpu_we_i;
                        wb_stb_q  <= 1'b1;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush_i || done) begin
                        wb_addr_q <= '0;
                        wb_data_q <= '0;
                        wb_sel_q  <= '0;
                        wb_we_q   <= 1'b0;
                        wb_stb_q  <= 1'b0;
                    end
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (done) begin
                        if (term_err)      hold_q <= '0;
                        else if (!wb_we_q) hold_q <= wb_data_i;
                        state_q <= stage_stall ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (!stage_stall || flush_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_addr_o = wb_addr_q;
    assign wb_data_o = wb_data_q;
    assign wb_sel_o  = wb_sel_q;
    assign wb_we_o   = wb_we_q;
    assign wb_stb_o  = wb_stb_q;
    assign wb_cyc_o  = wb_stb_q;

endmodule : wb_master_if

// File: tb/tb_wb_master_if.sv
// Directed bench for wb_master_if (TMO=4, STAGE=1). Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_wb_master_if;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int STALLW = 6;

    logic              clk = 1'b0;
    logic              rstn;
    logic [STALLW-1:0] stall_i;
    logic              flush_i, cpu_ce_i, cpu_we_i;
    logic [DW/8-1:0]   cpu_sel_i;
    logic [AW-1:0]     cpu_addr_i;
    logic [DW-1:0]     cpu_data_i, cpu_data_o, wb_data_i, wb_data_o;
    logic              stallreq, bus_err_o, wb_ack_i, wb_err_i;
    logic [AW-1:0]     wb_addr_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic              wb_we_o, wb_stb_o, wb_cyc_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_master_if #(.DW(DW), .AW(AW), .STALLW(STALLW), .STAGE(1), .TMO(4)) dut (
        .clk(clk), .rstn(rstn), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stallreq(stallreq), .bus_err_o(bus_err_o), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_data_i(wb_data_i), .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic req(input logic we, input logic [AW-1:0] a, input logic [3:0] s,
                       input logic [DW-1:0] d);
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_sel_i = s; cpu_data_i = d;
    endtask

    task automatic idle_cpu();
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
    endtask

    initial begin
        rstn = 1'b0; stall_i = '0; flush_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        wb_data_i = '0; idle_cpu();

        // Reset state
        #12;
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stallreq", stallreq, 0);
        chk("rst_cpu_data", cpu_data_o, 0);
        chk("rst_bus_err", bus_err_o, 0);
        chk("rst_addr", wb_addr_o, 0);
        rstn = 1'b1;
        tick();

        // Zero-wait read
        req(1'b0, 32'h0000_1000, 4'hF, 32'h0);
        smp();
        chk("rd_req_stallreq", stallreq, 1);
        chk("rd_req_stb", wb_stb_o, 0);
        tick();
        idle_cpu(); wb_ack_i = 1'b1; wb_data_i = 32'hDEAD_BEEF;
        smp();
        chk("rd_ack_stb", wb_stb_o, 1);
        chk("rd_ack_cyc", wb_cyc_o, 1);
        chk("rd_ack_addr", wb_addr_o, 32'h0000_1000);
        chk("rd_ack_we", wb_we_o, 0);
        chk("rd_ack_data", cpu_data_o, 32'hDEAD_BEEF);
        chk("rd_ack_stallreq", stallreq, 0);
        tick();
        wb_ack_i = 1'b0; wb_data_i = '0;
        smp();
        chk("rd_end_stb", wb_stb_o, 0);
        chk("rd_end_cyc", wb_cyc_o, 0);
        chk("rd_end_data", cpu_data_o, 0);

        // Read that lands in HOLD for three stalled cycles
        tick();
        req(1'b0, 32'h0000_1000, 4'hF, 32'h0);
        tick();
        idle_cpu(); wb_ack_i = 1'b1; wb_data_i = 32'hDEAD_BEEF; stall_i = 6'b000010;
        smp();
        chk("hold_ack_data", cpu_data_o, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            wb_ack_i = 1'b0; wb_data_i = 32'h1111_2222;
            cpu_ce_i = (i == 1);
            smp();
            chk("hold_data", cpu_data_o, 32'hDEAD_BEEF);
            chk("hold_stb", wb_stb_o, 0);
            chk("hold_stallreq", stallreq, 0);
        end
        tick();
        cpu_ce_i = 1'b0; stall_i = '0;
        smp();
        chk("hold_no_new_req", wb_stb_o, 0);
        chk("hold_last_data", cpu_data_o, 32'hDEAD_BEEF);
        tick();
        smp();
        chk("hold_exit_data", cpu_data_o, 0);
        chk("hold_exit_stb", wb_stb_o, 0);

        // Write with three wait states
        tick();
        req(1'b1, 32'h10, 4'b0011, 32'h1234_5678);
        smp();
        chk("wr_req_stallreq", stallreq, 1);
        tick();
        idle_cpu();
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("wr_wait_stb", wb_stb_o, 1);
            chk("wr_wait_we", wb_we_o, 1);
            chk("wr_wait_sel", wb_sel_o, 4'b0011);
            chk("wr_wait_stallreq", stallreq, 1);
            tick();
        end
        wb_ack_i = 1'b1;
        smp();
        chk("wr_ack_addr", wb_addr_o, 32'h10);
        chk("wr_ack_data", wb_data_o, 32'h1234_5678);
        chk("wr_ack_we", wb_we_o, 1);
        chk("wr_ack_sel", wb_sel_o, 4'b0011);
        chk("wr_ack_stallreq", stallreq, 0);
        tick();
        wb_ack_i = 1'b0;
        smp();
        chk("wr_end_stb", wb_stb_o, 0);

        // Flush in the second BUSY cycle, late ack ignored
        tick();
        req(1'b0, 32'h20, 4'hF, 32'h0);
        tick();
        idle_cpu();
        smp();
        chk("fl_busy1_stallreq", stallreq, 1);
        tick();
        flush_i = 1'b1;
        smp();
        chk("fl_stallreq", stallreq, 0);
        chk("fl_bus_err", bus_err_o, 0);
        chk("fl_stb_still", wb_stb_o, 1);
        tick();
        flush_i = 1'b0;
        smp();
        chk("fl_stb_drop", wb_stb_o, 0);
        chk("fl_cyc_drop", wb_cyc_o, 0);
        tick();
        wb_ack_i = 1'b1; wb_data_i = 32'hAAAA_5555;
        smp();
        chk("fl_late_ack_data", cpu_data_o, 0);
        chk("fl_late_ack_err", bus_err_o, 0);
        chk("fl_late_ack_stallreq", stallreq, 0);
        tick();
        wb_ack_i = 1'b0; wb_data_i = '0;
        smp();
        chk("fl_after_stb", wb_stb_o, 0);

        // Timeout after four BUSY cycles without response
        tick();
        req(1'b0, 32'h30, 4'hF, 32'h0);
        tick();
        idle_cpu();
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("to_wait_err", bus_err_o, 0);
            chk("to_wait_stb", wb_stb_o, 1);
            chk("to_wait_stallreq", stallreq, 1);
            tick();
        end
        smp();
        chk("to_err_pulse", bus_err_o, 1);
        chk("to_err_data", cpu_data_o, 0);
        chk("to_err_stallreq", stallreq, 0);
        tick();
        smp();
        chk("to_after_err", bus_err_o, 0);
        chk("to_after_stb", wb_stb_o, 0);

        // Simultaneous ack and err: error wins
        tick();
        req(1'b0, 32'h34, 4'hF, 32'h0);
        tick();
        idle_cpu(); wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_data_i = 32'hCAFE_F00D;
        smp();
        chk("ae_data", cpu_data_o, 0);
        chk("ae_err", bus_err_o, 1);
        chk("ae_stallreq", stallreq, 0);
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_data_i = '0;
        smp();
        chk("ae_after_stb", wb_stb_o, 0);
        chk("ae_after_err", bus_err_o, 0);

        // Reset mid-BUSY, then a clean read
        tick();
        req(1'b0, 32'h40, 4'hF, 32'h0);
        tick();
        idle_cpu();
        smp();
        chk("mr_busy_stb", wb_stb_o, 1);
        #1 rstn = 1'b0;
        #1;
        chk("mr_stb", wb_stb_o, 0);
        chk("mr_cyc", wb_cyc_o, 0);
        chk("mr_addr", wb_addr_o, 0);
        chk("mr_stallreq", stallreq, 0);
        chk("mr_cpu_data", cpu_data_o, 0);
        chk("mr_bus_err", bus_err_o, 0);
        tick();
        rstn = 1'b1;
        req(1'b0, 32'h44, 4'hF, 32'h0);
        smp();
        chk("mr_new_stallreq", stallreq, 1);
        tick();
        idle_cpu(); wb_ack_i = 1'b1; wb_data_i = 32'h0BAD_F00D;
        smp();
        chk("mr_new_addr", wb_addr_o, 32'h44);
        chk("mr_new_data", cpu_data_o, 32'h0BAD_F00D);
        tick();
        wb_ack_i = 1'b0; wb_data_i = '0;
        smp();
        chk("mr_new_end_stb", wb_stb_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wb_master_if
